// File: rtl/subleq_core.sv
// subleq_core: multi-cycle SUBLEQ processor driving one request/response memory port
// Each instruction reads A, B, C at pc..pc+2 and then mem[A] and mem[B]. It writes
// mem[B] - mem[A] back to B, then branches to C when the result is <= 0, else goes to pc+3.
// Ports: clock, rst_n (sync active-low) | run gates instruction start in IDLE
//   mem_req/mem_we/mem_addr/mem_wdata -> request, accepted by mem_ready
//   mem_rvalid/mem_rdata <- read response, at most one read outstanding
//   pc, halted, instr_count -> architectural status
// Optional: define SUBLEQ_HALT_EN to stop the core on a taken branch whose C word is negative.
module subleq_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count
);
  typedef enum logic [3:0] {
    IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, REQ_C, WAIT_C,
    REQ_MA, WAIT_MA, REQ_MB, WAIT_MB, WRITE, HALTED
  } state_e;
  state_e state_q;
  logic [ADDR_W-1:0] pc_q, a_q, b_q, c_q, pc_d;
  logic [DATA_W-1:0] opa_q, opb_q, diff_d;
  logic [31:0] count_q;
  logic leq_d, halt_d;
  assign diff_d = opb_q - opa_q;
  assign leq_d = diff_d[DATA_W-1] | ~|diff_d;
  assign pc_d = leq_d ? c_q : pc_q + ADDR_W'(3);
`ifdef SUBLEQ_HALT_EN
  logic c_neg_q;
  assign halt_d = leq_d & c_neg_q;
  assign halted = state_q == HALTED;
`else
  assign halt_d = 1'b0;
  assign halted = 1'b0;
`endif
  assign mem_req = state_q inside {REQ_A, REQ_B, REQ_C, REQ_MA, REQ_MB, WRITE};
  assign mem_we = state_q == WRITE;
  assign mem_wdata = mem_we ? diff_d : '0;
  assign mem_addr = state_q == REQ_A  ? pc_q :
                    state_q == REQ_B  ? pc_q + ADDR_W'(1) :
                    state_q == REQ_C  ? pc_q + ADDR_W'(2) :
                    state_q == REQ_MA ? a_q :
                    (state_q == REQ_MB || state_q == WRITE) ? b_q : '0;
  assign pc = pc_q;
  assign instr_count = count_q;
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      count_q <= '0;
`ifdef SUBLEQ_HALT_EN
      c_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:    if (run) state_q <= REQ_A;
        REQ_A:   if (mem_ready) state_q <= WAIT_A;
        REQ_B:   if (mem_ready) state_q <= WAIT_B;
        REQ_C:   if (mem_ready) state_q <= WAIT_C;
        REQ_MA:  if (mem_ready) state_q <= WAIT_MA;
        REQ_MB:  if (mem_ready) state_q <= WAIT_MB;
        WAIT_A:  if (mem_rvalid) begin
          a_q <= mem_rdata[ADDR_W-1:0];
          state_q <= REQ_B;
        end
        WAIT_B:  if (mem_rvalid) begin
          b_q <= mem_rdata[ADDR_W-1:0];
          state_q <= REQ_C;
        end
        WAIT_C:  if (mem_rvalid) begin
          c_q <= mem_rdata[ADDR_W-1:0];
`ifdef SUBLEQ_HALT_EN
          c_neg_q <= mem_rdata[DATA_W-1];
`endif
          state_q <= REQ_MA;
        end
        WAIT_MA: if (mem_rvalid) begin
          opa_q <= mem_rdata;
          state_q <= REQ_MB;
        end
        WAIT_MB: if (mem_rvalid) begin
          opb_q <= mem_rdata;
          state_q <= WRITE;
        end
        WRITE:   if (mem_ready) begin
          // a halting instruction still retires, but pc keeps the address of the halting instruction
          count_q <= count_q + 32'd1;
          if (!halt_d) pc_q <= pc_d;
          state_q <= halt_d ? HALTED : IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core: table, directed and random checks of subleq_core against a behavioural SUBLEQ model
module tb_subleq_core;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  int nvec = 0, nerr = 0;
`ifdef SUBLEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic rst32, run32, req32, we32, rdy32, rv32, h32;
  logic [15:0] addr32, pc32;
  logic [31:0] wd32, rd32, ic32;
  int lat32, cnt32 = 0;
  logic [31:0] mem32 [65536];
  logic rst8, run8, req8, we8, rdy8, rv8, h8;
  logic [3:0] addr8, pc8;
  logic [7:0] wd8, rd8;
  logic [31:0] ic8;
  int lat8, cnt8 = 0;
  logic [7:0] mem8 [16];
  int mref [16];
  int bp;
  bit snap, rnd;
  logic [15:0] s_addr;
  logic [31:0] s_wd;
  logic s_we;

  subleq_core u32 (
    .clock(clock), .rst_n(rst32), .run(run32), .mem_req(req32), .mem_we(we32),
    .mem_addr(addr32), .mem_wdata(wd32), .mem_ready(rdy32), .mem_rvalid(rv32),
    .mem_rdata(rd32), .pc(pc32), .halted(h32), .instr_count(ic32)
  );
  subleq_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'd14)) u8 (
    .clock(clock), .rst_n(rst8), .run(run8), .mem_req(req8), .mem_we(we8),
    .mem_addr(addr8), .mem_wdata(wd8), .mem_ready(rdy8), .mem_rvalid(rv8),
    .mem_rdata(rd8), .pc(pc8), .halted(h8), .instr_count(ic8)
  );

  // memories: one read slot each, rvalid pulses lat cycles after acceptance
  always @(posedge clock) begin
    if (!rst32) cnt32 <= 0;
    else begin
      if (cnt32 > 0) cnt32 <= cnt32 - 1;
      if (req32 && rdy32) begin
        if (we32) mem32[addr32] = wd32;
        else begin
          cnt32 <= lat32;
          rd32 <= mem32[addr32];
        end
      end
    end
  end
  assign rv32 = cnt32 == 1;
  always @(posedge clock) begin
    if (!rst8) cnt8 <= 0;
    else begin
      if (cnt8 > 0) cnt8 <= cnt8 - 1;
      if (req8 && rdy8) begin
        if (we8) mem8[addr8] = wd8;
        else begin
          cnt8 <= lat8;
          rd8 <= mem8[addr8];
        end
      end
    end
  end
  assign rv8 = cnt8 == 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic reset32();
    run32 = 1'b0;
    rst32 = 1'b0;
    repeat (2) @(negedge clock);
    rst32 = 1'b1;
  endtask

  task automatic load32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] va, input logic [31:0] vb);
    for (int i = 0; i < 64; i++) mem32[i] = '0;
    mem32[0] = a;
    mem32[1] = b;
    mem32[2] = c;
    mem32[a[15:0]] = va;
    mem32[b[15:0]] = vb;
  endtask

  // one instruction: returns cycles from first request to the write-accept cycle, inclusive
  task automatic go32(output int cyc);
    int t;
    t = 0;
    cyc = 0;
    snap = 1'b0;
    run32 = 1'b1;
    while (!req32 && t < 50) begin
      @(negedge clock);
      t++;
    end
    run32 = 1'b0;
    chk("start32", req32, 1);
    if (!req32) return;
    cyc = 1;
    while (!(req32 && we32 && rdy32) && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (bp > 0 && req32 && !we32 && addr32 == pc32 + 16'd1) begin
        if (snap) begin
          chk("bp_addr", addr32, s_addr);
          chk("bp_we", we32, s_we);
          chk("bp_wdata", wd32, s_wd);
        end else begin
          snap = 1'b1;
          s_addr = addr32;
          s_we = we32;
          s_wd = wd32;
        end
        rdy32 = 1'b0;
        bp--;
      end else rdy32 = 1'b1;
    end
    chk("wr32_seen", req32 && we32 && rdy32, 1);
    @(negedge clock);
  endtask

  task automatic go8();
    int t, c;
    t = 0;
    c = 0;
    run8 = 1'b1;
    while (!req8 && t < 50) begin
      @(negedge clock);
      t++;
    end
    run8 = 1'b0;
    chk("start8", req8, 1);
    if (!req8) return;
    while (!(req8 && we8 && rdy8) && c < 400) begin
      @(negedge clock);
      c++;
      rdy8 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      lat8 = rnd ? int'($urandom_range(1, 4)) : 1;
    end
    chk("wr8_seen", req8 && we8 && rdy8, 1);
    @(negedge clock);
  endtask

  task automatic seed8();
    rst8 = 1'b0;
    run8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem8[i] = 8'($urandom);
      mref[i] = int'(mem8[i]);
    end
    repeat (2) @(negedge clock);
    rst8 = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a, b, c, va, vb, diff;
    logic [15:0] npc;
  } vec_t;
  vec_t vt [6];

  initial begin
    int cyc, t, pcm, icm, a, b, c, d, reqs;
    bit leq, hlt;
    rst32 = 1'b0; run32 = 1'b1; rdy32 = 1'b1; lat32 = 1; bp = 0;
    rst8 = 1'b0; run8 = 1'b0; rdy8 = 1'b1; lat8 = 1; rnd = 1'b0;
    for (int i = 0; i < 65536; i++) mem32[i] = '0;
    repeat (2) @(negedge clock);
    chk("rst_req", req32, 0);
    chk("rst_we", we32, 0);
    chk("rst_addr", addr32, 0);
    chk("rst_wdata", wd32, 0);
    chk("rst_pc", pc32, 0);
    chk("rst_halted", h32, 0);
    chk("rst_count", ic32, 0);
    run32 = 1'b0;
    rst32 = 1'b1;

    vt[0] = '{32'd10, 32'd11, 32'd3,  32'd5, 32'd7, 32'd2, 16'd3};
    vt[1] = '{32'd10, 32'd11, 32'd20, 32'd7, 32'd7, 32'd0, 16'd20};
    vt[2] = '{32'd10, 32'd10, 32'd5,  32'd9, 32'd9, 32'd0, 16'd5};
    vt[3] = '{32'd12, 32'd13, 32'd40, 32'd5, 32'd3, 32'hFFFF_FFFE, 16'd40};
    vt[4] = '{32'd12, 32'd13, 32'd40, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 16'd3};
    vt[5] = '{32'd12, 32'd13, 32'd40, 32'h8000_0000, 32'd0, 32'h8000_0000, 16'd40};
    for (int i = 0; i < 6; i++) begin
      reset32();
      load32(vt[i].a, vt[i].b, vt[i].c, vt[i].va, vt[i].vb);
      go32(cyc);
      chk($sformatf("v%0d_mem", i), mem32[vt[i].b[15:0]], vt[i].diff);
      chk($sformatf("v%0d_pc", i), pc32, vt[i].npc);
      chk($sformatf("v%0d_count", i), ic32, 1);
      chk($sformatf("v%0d_halted", i), h32, 0);
      if (i == 0) chk("v0_cycles", cyc, 11);
    end

    reset32();
    load32(32'd10, 32'd11, 32'd3, 32'd5, 32'd7);
    lat32 = 5;
    bp = 3;
    go32(cyc);
    chk("bp_mem", mem32[11], 2);
    chk("bp_pc", pc32, 3);
    chk("bp_stalls", bp, 0);
    lat32 = 1;
    bp = 0;

    reset32();
    load32(32'd10, 32'd11, 32'd3, 32'd5, 32'd7);
    run32 = 1'b1;
    t = 0;
    while (!req32 && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    rst32 = 1'b0;
    run32 = 1'b0;
    @(negedge clock);
    chk("midrst_req", req32, 0);
    chk("midrst_pc", pc32, 0);
    rst32 = 1'b1;
    go32(cyc);
    chk("midrst_mem", mem32[11], 2);
    chk("midrst_count", ic32, 1);

    reset32();
    load32(32'd10, 32'd11, 32'hFFFF_FFFF, 32'd7, 32'd7);
    go32(cyc);
    chk("halt_mem", mem32[11], 0);
    chk("halt_count", ic32, 1);
`ifdef SUBLEQ_HALT_EN
    chk("halt_flag", h32, 1);
    chk("halt_pc", pc32, 0);
    run32 = 1'b1;
    reqs = 0;
    repeat (20) begin
      @(negedge clock);
      if (req32) reqs++;
    end
    chk("halt_noreq", reqs, 0);
`else
    chk("nohalt_flag", h32, 0);
    chk("nohalt_pc", pc32, 16'hFFFF);
    run32 = 1'b1;
    t = 0;
    while (!req32 && t < 10) begin
      @(negedge clock);
      t++;
    end
    chk("nohalt_fetch", addr32, 16'hFFFF);
`endif
    reset32();

    rst8 = 1'b0;
    for (int i = 0; i < 16; i++) mem8[i] = '0;
    mem8[14] = 8'd5;
    mem8[15] = 8'd6;
    mem8[0] = 8'd9;
    mem8[5] = 8'h01;
    mem8[6] = 8'h80;
    repeat (2) @(negedge clock);
    rst8 = 1'b1;
    go8();
    chk("w8_diff", mem8[6], 8'h7F);
    chk("w8_pc", pc8, 1);
    chk("w8_count", ic8, 1);

    rnd = 1'b1;
    seed8();
    pcm = 14;
    icm = 0;
    for (int n = 0; n < 150; n++) begin
      go8();
      a = mref[pcm];
      b = mref[(pcm + 1) % 16];
      c = mref[(pcm + 2) % 16];
      d = (mref[b % 16] - mref[a % 16]) & 255;
      mref[b % 16] = d;
      leq = d == 0 || d >= 128;
      hlt = leq && c >= 128 && HALT_EN;
      pcm = hlt ? pcm : leq ? c % 16 : (pcm + 3) % 16;
      icm++;
      chk("rnd_mem", mem8[b % 16], d);
      chk("rnd_pc", pc8, pcm);
      chk("rnd_count", ic8, icm);
      chk("rnd_halted", h8, hlt);
      if (hlt) begin
        seed8();
        pcm = 14;
        icm = 0;
      end
    end
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_final%0d", i), mem8[i], mref[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
